// File: rtl/xalu_pkg.sv
// Shared types for the XALU multiply/divide unit: op encoding, FSM states and
// small op-class helpers used by the top level.
package xalu_pkg;

    typedef enum logic [3:0] {
        OP_MULT  = 4'd0,
        OP_MULTU = 4'd1,
        OP_DIV   = 4'd2,
        OP_DIVU  = 4'd3,
        OP_MADD  = 4'd4,
        OP_MADDU = 4'd5,
        OP_MSUB  = 4'd6,
        OP_MSUBU = 4'd7,
        OP_MUL   = 4'd8,
        OP_MTHI  = 4'd9,
        OP_MTLO  = 4'd10
    } xalu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MUL_RUN = 2'd1,
        ST_DIV_RUN = 2'd2
    } xalu_state_t;

    localparam int XALU_DIV_CYCLES = 33;

    function automatic logic is_mul_op(input xalu_op_t op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) ||
               (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU) ||
               (op == OP_MUL);
    endfunction

    function automatic logic is_signed_mul(input xalu_op_t op);
        return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/xalu_div.sv
// Iterative 32-bit restoring divider: 32 magnitude iterations followed by a
// combinational sign fix-up, with divide-by-zero forced to the MIPS-style result.
module xalu_div (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic        flush_i,
    input  logic        signed_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        done_o,
    output logic [31:0] quot_o,
    output logic [31:0] rem_o
);

    logic        run_q;
    logic [5:0]  cnt_q;
    logic [31:0] quo_q;
    logic [31:0] rem_q;
    logic [31:0] dvs_q;
    logic [31:0] a_q;
    logic        q_neg_q;
    logic        r_neg_q;
    logic        dvz_q;

    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic [32:0] rem_sh;
    logic        fits;
    logic [31:0] diff;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    assign a_neg = signed_i & a_i[31];
    assign b_neg = signed_i & b_i[31];
    assign a_abs = a_neg ? (~a_i + 32'd1) : a_i;
    assign b_abs = b_neg ? (~b_i + 32'd1) : b_i;

    // The running remainder is always below the divisor, so the difference fits 32 bits.
    assign rem_sh = {rem_q, quo_q[31]};
    assign fits   = (rem_sh >= {1'b0, dvs_q});
    assign diff   = rem_sh[31:0] - dvs_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_q   <= 1'b0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            a_q     <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dvz_q   <= 1'b0;
        end else if (flush_i) begin
            run_q <= 1'b0;
            cnt_q <= '0;
        end else if (start_i) begin
            run_q   <= 1'b1;
            cnt_q   <= '0;
            quo_q   <= a_abs;
            rem_q   <= '0;
            dvs_q   <= b_abs;
            a_q     <= a_i;
            q_neg_q <= a_neg ^ b_neg;
            r_neg_q <= a_neg;
            dvz_q   <= (b_i == 32'd0);
        end else if (run_q) begin
            if (cnt_q == 6'd32) begin
                run_q <= 1'b0;
            end else begin
                quo_q <= {quo_q[30:0], fits};
                rem_q <= fits ? diff : rem_sh[31:0];
                cnt_q <= cnt_q + 6'd1;
            end
        end
    end

    // 0x80000000 / -1 needs no special case: magnitude 2^31 negated wraps back to itself.
    assign q_fix  = q_neg_q ? (~quo_q + 32'd1) : quo_q;
    assign r_fix  = r_neg_q ? (~rem_q + 32'd1) : rem_q;
    assign done_o = run_q && (cnt_q == 6'd32);
    assign quot_o = dvz_q ? 32'hFFFF_FFFF : q_fix;
    assign rem_o  = dvz_q ? a_q : r_fix;

endmodule

// File: rtl/xalu.sv
// Execute-stage multiply/divide unit holding architectural HI/LO. Multiplies
// run through a MUL_CYCLES-deep product pipeline; divides use xalu_div.
module xalu
    import xalu_pkg::*;
#(
    parameter int MUL_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  xalu_op_t    op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        mul_done,
    output logic [31:0] mul_result
);

    xalu_state_t state_q, state_d;
    logic [5:0]  count_q, count_d;
    xalu_op_t    op_q, op_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;
    logic        mul_done_q, mul_done_d;
    logic [31:0] mul_result_q, mul_result_d;
    logic [63:0] pipe_q [MUL_CYCLES];

    logic        mul_launch;
    logic        div_launch;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] mul_prod;
    logic [63:0] prod;
    logic [63:0] acc;
    logic        div_done;
    logic [31:0] div_quot;
    logic [31:0] div_rem;

    // Low 64 bits of a 64x64 product of the extended operands give both signed and unsigned results.
    assign ext_a    = is_signed_mul(op) ? {{32{a[31]}}, a} : {32'd0, a};
    assign ext_b    = is_signed_mul(op) ? {{32{b[31]}}, b} : {32'd0, b};
    assign mul_prod = ext_a * ext_b;
    assign prod     = pipe_q[MUL_CYCLES-1];
    assign acc      = {hi_q, lo_q};

    xalu_div u_div (
        .clk      (clk),
        .reset    (reset),
        .start_i  (div_launch),
        .flush_i  (flush),
        .signed_i (op == OP_DIV),
        .a_i      (a),
        .b_i      (b),
        .done_o   (div_done),
        .quot_o   (div_quot),
        .rem_o    (div_rem)
    );

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        op_d         = op_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        mul_done_d   = 1'b0;
        mul_result_d = mul_result_q;
        mul_launch   = 1'b0;
        div_launch   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    if (op == OP_MTHI) begin
                        hi_d = a;
                    end else if (op == OP_MTLO) begin
                        lo_d = a;
                    end else if (is_mul_op(op)) begin
                        mul_launch = 1'b1;
                        state_d    = ST_MUL_RUN;
                        count_d    = 6'(MUL_CYCLES);
                        op_d       = op;
                    end else if (op == OP_DIV || op == OP_DIVU) begin
                        div_launch = 1'b1;
                        state_d    = ST_DIV_RUN;
                        count_d    = 6'(XALU_DIV_CYCLES);
                        op_d       = op;
                    end
                end
            end
            ST_MUL_RUN: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end else if (count_q == 6'd1) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                    case (op_q)
                        OP_MULT, OP_MULTU: {hi_d, lo_d} = prod;
                        OP_MADD, OP_MADDU: {hi_d, lo_d} = acc + prod;
                        OP_MSUB, OP_MSUBU: {hi_d, lo_d} = acc - prod;
                        OP_MUL: begin
                            mul_result_d = prod[31:0];
                            mul_done_d   = 1'b1;
                        end
                        default: ;
                    endcase
                end else begin
                    count_d = count_q - 6'd1;
                end
            end
            ST_DIV_RUN: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end else if (count_q == 6'd1) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                    hi_d    = div_rem;
                    lo_d    = div_quot;
                end else begin
                    count_d = count_q - 6'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            op_q         <= OP_MULT;
            hi_q         <= '0;
            lo_q         <= '0;
            busy_q       <= 1'b0;
            mul_done_q   <= 1'b0;
            mul_result_q <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            op_q         <= op_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            busy_q       <= busy_d;
            mul_done_q   <= mul_done_d;
            mul_result_q <= mul_result_d;
        end
    end

    // Product enters at the start edge and shifts once per cycle; the last stage is read at commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MUL_CYCLES; i++) pipe_q[i] <= '0;
        end else begin
            if (mul_launch) pipe_q[0] <= mul_prod;
            for (int i = 1; i < MUL_CYCLES; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    a_no_start_when_busy: assert property (@(posedge clk) disable iff (reset)
        !(start && busy_q));
    a_div_ready_at_commit: assert property (@(posedge clk) disable iff (reset)
        (state_q == ST_DIV_RUN && count_q == 6'd1) |-> div_done);

    assign busy       = busy_q;
    assign hi         = hi_q;
    assign lo         = lo_q;
    assign mul_done   = mul_done_q;
    assign mul_result = mul_result_q;

endmodule
